ysyx_22040759_rdaxi_burst: RTL
==============================

YSYX_22040759_RDAXI_BURST -- requirements
Module: ysyx_22040759_rdaxi_burst

Interface
REQ-001 SHALL have parameter RD_DATA_WIDTH, default 256, meaning the line width in bits; it is an integer multiple of AXI_DATA_WIDTH, from 64 to 512.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning the R data bus width.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 64, meaning the address width.
REQ-004 SHALL have parameter AXI_ID_WIDTH, default 4, meaning the ID width.
REQ-005 SHALL have parameter RD_ID, default 0, meaning the constant driven on axi_ar_id_o.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rd_req_valid_i, input, 1 bit: request valid.
REQ-009 SHALL have port rd_req_ready_o, output, 1 bit: request accepted.
REQ-010 SHALL have port rd_addr_i, input, AXI_ADDR_WIDTH bits: byte address.
REQ-011 SHALL have port rd_size_i, input, 2 bits: scalar size (0=B, 1=H, 2=W, 3=D).
REQ-012 SHALL have port rd_line_i, input, 1 bit: 1 selects a line fill of RD_DATA_WIDTH bits; 0 selects a scalar read.
REQ-013 SHALL have port rd_data_valid_o, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port rd_data_o, output, RD_DATA_WIDTH bits: read result.
REQ-015 SHALL have port rd_err_o, output, 1 bit: the transaction saw an error response.
REQ-016 SHALL have AR ports axi_ar_valid_o and axi_ar_ready_i (1 bit each); axi_ar_addr_o (AXI_ADDR_WIDTH); axi_ar_id_o (AXI_ID_WIDTH); axi_ar_len_o (8); axi_ar_size_o (3); and axi_ar_burst_o (2).
REQ-017 SHALL drive the following outputs as constants: axi_ar_prot_o=3'b000, axi_ar_lock_o=0, axi_ar_cache_o=4'b0000, axi_ar_qos_o=0, axi_ar_user_o=0.
REQ-018 SHALL have R ports axi_r_valid_i (input, 1), axi_r_ready_o (output, 1), axi_r_resp_i (input, 2), axi_r_data_i (input, AXI_DATA_WIDTH) and axi_r_last_i (input, 1).

Function
REQ-019 SHALL implement the states IDLE, ADDR, READ and DONE, with transitions IDLE->ADDR on request handshake, ADDR->READ on AR handshake, READ->DONE on an R handshake with axi_r_last_i=1, and DONE->IDLE unconditionally.
REQ-020 SHALL assert rd_req_ready_o only in IDLE, and SHALL latch addr, size and line on the request handshake; the request inputs are don't-care afterwards.
REQ-021 SHALL assert axi_ar_valid_o exactly in ADDR, and SHALL hold axi_ar_addr_o and axi_ar_len_o stable until axi_ar_ready_i is sampled high.
REQ-022 SHALL issue a line read as: address with its low log2(RD_DATA_WIDTH/8) bits cleared, axi_ar_len_o=RD_DATA_WIDTH/AXI_DATA_WIDTH-1, INCR burst, axi_ar_size_o=log2(AXI_DATA_WIDTH/8).
REQ-023 SHALL issue a scalar read as: address aligned to AXI_DATA_WIDTH/8, axi_ar_len_o=1 if (offset+bytes-1) crosses the bus word and 0 otherwise, INCR burst.
REQ-024 SHALL assert axi_r_ready_o exactly in READ, and SHALL clear an 8-bit beat counter on entry to READ and increment it on each R handshake.
REQ-025 SHALL, in line mode, write beat i to rd_data_o[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], and SHALL discard beats with index above len without corrupting data.
REQ-026 SHALL, in scalar mode, right-shift the requested bytes of beat 0 by offset*8, OR beat 1's low bytes in at bit (AXI_DATA_WIDTH-offset*8), and zero-extend the result into rd_data_o with bits above the size set to 0.
REQ-027 SHALL clear the scalar data register on request acceptance.
REQ-028 SHALL pulse rd_data_valid_o high only in DONE, exactly one cycle after the last R handshake, and SHALL hold rd_data_o stable from DONE until the next request is accepted.
REQ-029 SHALL accept a request presented during DONE no earlier than the following IDLE cycle, giving a minimum request-to-request spacing of 4 cycles plus slave latency.

Reset
REQ-030 SHALL, when rst is sampled high, enter IDLE on the same edge and drive rd_req_ready_o=1 and axi_ar_valid_o, axi_r_ready_o, rd_data_valid_o, rd_err_o and rd_data_o all 0 from the next cycle.
REQ-031 SHALL allow reset at any state, including mid-burst, with the in-flight transaction abandoned; the system resets the slave concurrently.

Configuration
REQ-032 SHALL, when YSYX_22040759_RDAXI_ERR_EN is defined, set rd_err_o as the OR of axi_r_resp_i[1] over all beats of the transaction, clear it on request acceptance, and make it valid while rd_data_valid_o=1.
REQ-033 SHALL, when YSYX_22040759_RDAXI_ERR_EN is undefined, tie rd_err_o to 0 and ignore axi_r_resp_i.

Verification
REQ-034 SHALL cover a line read: RD_DATA_WIDTH=256, addr 0x8000_0014, line=1 -> ar_addr=0x8000_0000, ar_len=3; four beats fill rd_data_o in order; valid pulses 1 cycle after the beat-3 handshake.
REQ-035 SHALL cover an aligned scalar read: addr 0x8000_0008, size=W, beat 0x1122334455667788 -> ar_len=0, rd_data_o=0x55667788.
REQ-036 SHALL cover a crossing scalar read: addr 0x8000_0006, size=W, beats 0xAABB000000000000 and 0x000000000000CCDD -> ar_len=1, rd_data_o=0xCCDDAABB.
REQ-037 SHALL cover backpressure: axi_ar_ready_i held low for 5 cycles, then axi_r_valid_i toggling -> AR fields stable throughout and no beat lost.
REQ-038 SHALL cover reset mid-burst: rst asserted after beat 1 of 4 -> IDLE next cycle, no valid pulse, and a subsequent request completes correctly.
REQ-039 SHALL cover the error flag: ERR_EN defined, beat 2 resp=2'b10 -> rd_err_o=1 with valid; ERR_EN undefined -> rd_err_o=0.

Source files
------------

// File: rtl/ysyx_22040759_rdaxi_burst.sv
// ysyx_22040759_rdaxi_burst: AXI4 read master for cache-line fills and scalar loads.
//   Request side : rd_req_valid_i/rd_req_ready_o handshake with rd_addr_i, rd_size_i, rd_line_i.
//   Result side  : rd_data_valid_o one-cycle pulse with rd_data_o and rd_err_o.
//   AXI AR       : single INCR burst per request; constant prot/lock/cache/qos/user.
//   AXI R        : beats collected into a line or shifted/merged into a scalar.
// Optional feature macro: YSYX_22040759_RDAXI_ERR_EN. When defined, rd_err_o reports
// any SLVERR/DECERR seen on R; when undefined, rd_err_o is 0 and axi_r_resp_i is ignored.
module ysyx_22040759_rdaxi_burst #(
  parameter int unsigned RD_DATA_WIDTH  = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned RD_ID          = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_req_valid_i,
  output logic                      rd_req_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [1:0]                rd_size_i,
  input  logic                      rd_line_i,
  output logic                      rd_data_valid_o,
  output logic [RD_DATA_WIDTH-1:0]  rd_data_o,
  output logic                      rd_err_o,
  output logic                      axi_ar_valid_o,
  input  logic                      axi_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
  output logic [7:0]                axi_ar_len_o,
  output logic [2:0]                axi_ar_size_o,
  output logic [1:0]                axi_ar_burst_o,
  output logic [2:0]                axi_ar_prot_o,
  output logic                      axi_ar_lock_o,
  output logic [3:0]                axi_ar_cache_o,
  output logic [3:0]                axi_ar_qos_o,
  output logic                      axi_ar_user_o,
  input  logic                      axi_r_valid_i,
  output logic                      axi_r_ready_o,
  input  logic [1:0]                axi_r_resp_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
  input  logic                      axi_r_last_i
);

  localparam int unsigned BUS_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int unsigned BUS_OFF_W  = $clog2(BUS_BYTES);
  localparam int unsigned LINE_BYTES = RD_DATA_WIDTH / 8;
  localparam int unsigned BEATS      = RD_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = ~(AXI_ADDR_WIDTH'(LINE_BYTES - 1));
  localparam logic [AXI_ADDR_WIDTH-1:0] BUS_MASK  = ~(AXI_ADDR_WIDTH'(BUS_BYTES - 1));

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_READ, ST_DONE} state_e;

  state_e                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic                      data_valid_q, data_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]                ar_len_q, ar_len_d;
  logic [1:0]                size_q, size_d;
  logic                      line_q, line_d;
  logic [BUS_OFF_W-1:0]      off_q, off_d;
  logic [7:0]                beat_q, beat_d;
  logic [RD_DATA_WIDTH-1:0]  data_q, data_d;
  logic                      err_q, err_d;

  logic [AXI_DATA_WIDTH-1:0] size_mask;
  logic [AXI_DATA_WIDTH-1:0] lo_part;
  logic [AXI_DATA_WIDTH-1:0] hi_part;
  int unsigned               sh_lo;
  int unsigned               sh_hi;
  int unsigned               end_byte;

  // Next-state, request latch and R-beat assembly.
  always_comb begin
    state_d   = state_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    size_d    = size_q;
    line_d    = line_q;
    off_d     = off_q;
    beat_d    = beat_q;
    data_d    = data_q;
    err_d     = err_q;

    // Scalar alignment: beat 0 supplies the low bytes, beat 1 the bytes that spilled over.
    size_mask = '0;
    for (int unsigned b = 0; b < AXI_DATA_WIDTH; b++) begin
      size_mask[b] = (b < (32'd8 << size_q));
    end
    sh_lo    = 32'(off_q) << 3;
    sh_hi    = AXI_DATA_WIDTH - sh_lo;
    lo_part  = (axi_r_data_i >> sh_lo) & size_mask;
    hi_part  = (axi_r_data_i << sh_hi) & size_mask;
    end_byte = 32'(rd_addr_i[BUS_OFF_W-1:0]) + (32'd1 << rd_size_i) - 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (rd_req_valid_i) begin
          state_d = ST_ADDR;
          size_d  = rd_size_i;
          line_d  = rd_line_i;
          off_d   = rd_addr_i[BUS_OFF_W-1:0];
          data_d  = '0;
          err_d   = 1'b0;
          if (rd_line_i) begin
            ar_addr_d = rd_addr_i & LINE_MASK;
            ar_len_d  = 8'(BEATS - 1);
          end else begin
            ar_addr_d = rd_addr_i & BUS_MASK;
            ar_len_d  = (end_byte >= BUS_BYTES) ? 8'd1 : 8'd0;
          end
        end
      end
      ST_ADDR: begin
        if (axi_ar_ready_i) begin
          state_d = ST_READ;
          beat_d  = 8'd0;
        end
      end
      ST_READ: begin
        if (axi_r_valid_i) begin
          beat_d = beat_q + 8'd1;
          // Beats past the requested length are dropped.
          if (beat_q <= ar_len_q) begin
            if (line_q) begin
              for (int unsigned i = 0; i < BEATS; i++) begin
                if (beat_q == 8'(i)) data_d[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = axi_r_data_i;
              end
            end else if (beat_q == 8'd0) begin
              data_d = RD_DATA_WIDTH'(lo_part);
            end else begin
              data_d = data_q | RD_DATA_WIDTH'(hi_part);
            end
          end
`ifdef YSYX_22040759_RDAXI_ERR_EN
          err_d = err_q | axi_r_resp_i[1];
`endif
          if (axi_r_last_i) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    ar_valid_d   = (state_d == ST_ADDR);
    r_ready_d    = (state_d == ST_READ);
    data_valid_d = (state_d == ST_DONE);
  end

`ifndef YSYX_22040759_RDAXI_ERR_EN
  logic unused_resp;
  assign unused_resp = ^axi_r_resp_i;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      data_valid_q <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= 8'd0;
      size_q       <= 2'd0;
      line_q       <= 1'b0;
      off_q        <= '0;
      beat_q       <= 8'd0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      data_valid_q <= data_valid_d;
      ar_addr_q    <= ar_addr_d;
      ar_len_q     <= ar_len_d;
      size_q       <= size_d;
      line_q       <= line_d;
      off_q        <= off_d;
      beat_q       <= beat_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  assign rd_req_ready_o  = req_ready_q;
  assign rd_data_valid_o = data_valid_q;
  assign rd_data_o       = data_q;
  assign rd_err_o        = err_q;
  assign axi_ar_valid_o  = ar_valid_q;
  assign axi_ar_addr_o   = ar_addr_q;
  assign axi_ar_len_o    = ar_len_q;
  assign axi_ar_id_o     = AXI_ID_WIDTH'(RD_ID);
  assign axi_ar_size_o   = 3'(BUS_OFF_W);
  assign axi_ar_burst_o  = 2'b01;
  assign axi_ar_prot_o   = 3'b000;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = 4'b0000;
  assign axi_ar_qos_o    = 4'b0000;
  assign axi_ar_user_o   = 1'b0;
  assign axi_r_ready_o   = r_ready_q;

endmodule
